screen_scanout: RTL
===================

// Module: screen_scanout
// PURPOSE
//  Read-side initiator for the Hack screen memory (RAM8K at 0x4000 in the Hack map).
//  Walks the 8K-word frame buffer line by line and serialises each 16-bit word into a
//  1-bit pixel stream with a valid/ready handshake, for the VGA/LCD or .pbm dump sink.
//  It never writes memory. It owns the screen RAM port only while busy; the CPU arbiter
//  holds it otherwise.
// PARAMETERS
//  REG_W           16   word width; pixels per fetched word
//  ADD_W           13   screen RAM address width (8192 words)
//  WORDS_PER_LINE  32   words per scanline (512 px)
//  LINES           256  scanlines per frame
// PORTS
//  clk         in   1      rising-edge clock, single domain
//  reset       in   1      synchronous, active-high
//  start       in   1      pulse: begin one frame scan; ignored while busy
//  busy        out  1      high from the cycle after an accepted start to frame_done
//  frame_done  out  1      one-cycle pulse after the last pixel of the frame is accepted
//  mem_address out  ADD_W  screen RAM word address
//  mem_load    out  1      constant 0 (reader never writes)
//  mem_out     in   REG_W  RAM read data for mem_address
//  pix_valid   out  1      pixel available
//  pix_ready   in   1      sink accepts the pixel when pix_valid && pix_ready
//  pix_data    out  1      1 = black, 0 = white
//  pix_sof     out  1      qualifies pix_data: first pixel of the frame (line 0, px 0)
//  pix_eol     out  1      qualifies pix_data: last pixel of a scanline (px 511)
// BEHAVIOUR
//  Reset: state IDLE. busy, frame_done, pix_valid, pix_sof and pix_eol are 0.
//   mem_address = 0. Word and line counters are 0.
//  FSM states: IDLE -> FETCH -> CAPTURE -> SHIFT -> (FETCH | DONE) -> IDLE.
//   IDLE: on start, clear the counters and go to FETCH.
//   FETCH: mem_address = line*WORDS_PER_LINE + word (wraps modulo 2^ADD_W).
//    Go to CAPTURE.
//   CAPTURE: hold the same address and sample mem_out into the shift register.
//    Set bit index = 0. Go to SHIFT. The RAM therefore gets one full cycle of address
//    setup, so both combinational and registered-read RAM work.
//   SHIFT: pix_valid = 1. pix_data = shreg[bit]. LSB is the leftmost pixel, per the
//    Hack screen mapping.
//    - Hold pix_data, pix_sof and pix_eol stable while !pix_ready.
//    - On accept with bit == REG_W-1: advance word; when word wraps, advance line.
//      If the accepted pixel was the last of the frame, go to DONE; otherwise FETCH.
//  DONE: frame_done = 1 for one cycle, busy drops the same cycle, then IDLE.
//  pix_sof = 1 only when line==0 && word==0 && bit==0.
//  pix_eol = 1 only when word==WORDS_PER_LINE-1 && bit==REG_W-1.
//  Throughput: 16 pixels per 18 cycles with pix_ready held high. The 2-cycle
//   FETCH/CAPTURE bubble between words is mandated. pix_valid is low during the bubble.
//  Backpressure: pix_ready low for any number of cycles stalls the FSM in SHIFT.
//   The memory is not re-read.
//  Memory changes during a frame: each word is sampled exactly once, in CAPTURE.
//   Later writes to that word affect only the next frame.
//  start while busy: ignored, with no restart and no queueing.
//   start in the frame_done cycle: ignored. start is accepted from IDLE only.
//  reset mid-frame: on the next edge, return to the reset state.
//   pix_valid drops without a final pixel. No frame_done.
//  Counter widths: word $clog2(WORDS_PER_LINE), line $clog2(LINES), bit $clog2(REG_W).
// STRUCTURE
//  hack_pkg: REG_W, SCREEN_BASE=16'h4000, SCREEN_ADD_W=13, WORDS_PER_LINE, LINES,
//   and the typedef enum scan_state_t {IDLE,FETCH,CAPTURE,SHIFT,DONE}.
//  Sub-module pixel_serializer: REG_W shift register, bit counter and valid/ready
//   handshake. Its ports are load/word in and valid/ready/data/last out.
//   The top holds the FSM, counters, address generation and the sof/eol flags.
// TESTING
//  Bench instantiates RAM #(.REG_W(16),.ADD_W(13)), preloads via in/load, and checks
//  with an x-terminated test-vector file like the existing RAM benches.
//  1 Word 0 = 16'h0001, rest 0, start, ready=1 -> first pixel 1 with pix_sof=1,
//    next 15 pixels 0. Total 131072 pixels. frame_done once, 18*8192+1 cycles after start.
//  2 Word 31 = 16'h8000 -> pix_eol=1 exactly on pixel 511, with pix_data=1.
//    Pixels 512..1023 are all 0. pix_eol is seen 256 times per frame.
//  3 pix_ready toggled 1,0,0,1 per cycle (pseudo-random) over a full frame
//    -> pixel stream bit-identical to scenario 1. Data is stable across all stall cycles.
//  4 Second start pulse at cycle 100 of a frame -> ignored: one frame_done, sof count = 1.
//  5 reset asserted at pixel 5000 -> next cycle pix_valid=0, busy=0, mem_address=0.
//    A subsequent start yields a full frame from sof.
//  6 Write word 8191 = 16'hFFFF from the bench while the scan is on line 0 -> the last 16
//    pixels are 1. The same write after word 8191's CAPTURE -> pixels 0 this frame, 1 the next.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared Hack platform constants and the screen scan-out state type.
package hack_pkg;

  localparam int          REG_W          = 16;
  localparam logic [15:0] SCREEN_BASE    = 16'h4000;
  localparam int          SCREEN_ADD_W   = 13;
  localparam int          WORDS_PER_LINE = 32;
  localparam int          LINES          = 256;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SHIFT,
    DONE
  } scan_state_t;

endpackage

// File: rtl/screen_scanout_pixel_serializer.sv
// Shifts one captured screen word out LSB-first (leftmost pixel first) under a
// valid/ready handshake; valid stays high until the last bit is accepted.
module pixel_serializer #(
  parameter int REG_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [REG_W-1:0] word,
  input  logic             ready,
  output logic             valid,
  output logic             data,
  output logic             last,
  output logic             first
);

  localparam int BIT_W = $clog2(REG_W);

  logic [REG_W-1:0] shreg;
  logic [BIT_W-1:0] bit_idx;
  logic             active;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_idx <= '0;
      active  <= 1'b0;
    end else if (load) begin
      shreg   <= word;
      bit_idx <= '0;
      active  <= 1'b1;
    end else if (active && ready) begin
      shreg <= shreg >> 1;
      if (bit_idx == BIT_W'(REG_W - 1)) begin
        active <= 1'b0;
      end else begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  assign valid = active;
  assign data  = shreg[0];
  assign last  = (bit_idx == BIT_W'(REG_W - 1));
  assign first = (bit_idx == '0);

endmodule

// File: rtl/screen_scanout.sv
// Frame-buffer reader: walks the screen RAM word by word, line by line, and
// streams each word out as pixels through the serializer.
//
// state   | meaning
// IDLE    | waiting for start; screen RAM port belongs to the CPU
// FETCH   | present line*WORDS_PER_LINE+word on mem_address
// CAPTURE | address held one more cycle, mem_out loaded into the serializer
// SHIFT   | pixels of the current word handed to the sink
// DONE    | one-cycle frame_done pulse, busy already low
module screen_scanout #(
  parameter int REG_W          = hack_pkg::REG_W,
  parameter int ADD_W          = hack_pkg::SCREEN_ADD_W,
  parameter int WORDS_PER_LINE = hack_pkg::WORDS_PER_LINE,
  parameter int LINES          = hack_pkg::LINES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  output logic [ADD_W-1:0] mem_address,
  output logic             mem_load,
  input  logic [REG_W-1:0] mem_out,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_data,
  output logic             pix_sof,
  output logic             pix_eol
);

  import hack_pkg::*;

  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = $clog2(LINES);

  scan_state_t       state, state_next;
  logic [WORD_W-1:0] word_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic              ser_load, ser_last, ser_first;
  logic              word_done, last_word_of_line, frame_last;

  pixel_serializer #(.REG_W(REG_W)) u_serializer (
    .clk   (clk),
    .reset (reset),
    .load  (ser_load),
    .word  (mem_out),
    .ready (pix_ready),
    .valid (pix_valid),
    .data  (pix_data),
    .last  (ser_last),
    .first (ser_first)
  );

  assign ser_load          = (state == CAPTURE);
  assign word_done         = pix_valid && pix_ready && ser_last;
  assign last_word_of_line = (word_cnt == WORD_W'(WORDS_PER_LINE - 1));
  assign frame_last        = last_word_of_line && (line_cnt == LINE_W'(LINES - 1));
  assign mem_load          = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = CAPTURE;
      CAPTURE: state_next = SHIFT;
      SHIFT:   if (word_done) state_next = frame_last ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters advance on acceptance of a word's last pixel and wrap back to 0
  // after the final word, so they already read 0 when the FSM returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt <= '0;
      line_cnt <= '0;
    end else if (state == IDLE && start) begin
      word_cnt <= '0;
      line_cnt <= '0;
    end else if (state == SHIFT && word_done) begin
      if (last_word_of_line) begin
        word_cnt <= '0;
        line_cnt <= (line_cnt == LINE_W'(LINES - 1)) ? '0 : line_cnt + 1'b1;
      end else begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    busy        = (state == FETCH) || (state == CAPTURE) || (state == SHIFT);
    frame_done  = (state == DONE);
    mem_address = ADD_W'(int'(line_cnt) * WORDS_PER_LINE + int'(word_cnt));
    pix_sof     = pix_valid && ser_first && (line_cnt == '0) && (word_cnt == '0);
    pix_eol     = pix_valid && ser_last && last_word_of_line;
  end

endmodule
